// File: rtl/clock_divider_prog.sv
// clock_divider_prog: programmable clock divider, divisor changes applied only at period boundaries.
// Optional 16-bit tick counter output enabled by defining CLKDIV_TICK_COUNT_EN.
module clock_divider_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             divclock,
  output logic             tick,
`ifdef CLKDIV_TICK_COUNT_EN
  output logic [15:0]      tick_count,
`endif
  output logic             busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0] state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx, n, n_nx, pend, pend_nx, load_val;
  logic [WIDTH:0] half;
  logic pend_v, pend_v_nx, wrap, tick_nx, dc_nx;
  // Outputs are computed from next-state values so they stay registered yet aligned with cnt.
  always_comb begin
    load_val  = (div_value == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : div_value;
    wrap      = (state == RUN) && (cnt == n - 1'b1);
    state_nx  = en ? RUN : IDLE;
    cnt_nx    = (state == RUN && en && !wrap) ? cnt + 1'b1 : '0;
    n_nx      = (state == IDLE) ? (div_load ? load_val : (pend_v ? pend : n))
                                : ((wrap && en && pend_v) ? pend : n);
    pend_nx   = (state == RUN && div_load) ? load_val : pend;
    pend_v_nx = (state == IDLE) ? 1'b0 : (div_load ? 1'b1 : ((wrap && en) ? 1'b0 : pend_v));
    tick_nx   = wrap && en;
    half      = ({1'b0, n_nx} + 1'b1) >> 1;
    dc_nx     = en && ({1'b0, cnt_nx} < half);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      n        <= WIDTH'(DEFAULT_DIV);
      pend     <= '0;
      pend_v   <= 1'b0;
      divclock <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      n        <= n_nx;
      pend     <= pend_nx;
      pend_v   <= pend_v_nx;
      divclock <= dc_nx;
      tick     <= tick_nx;
    end
  end
  assign busy = (state == RUN);
`ifdef CLKDIV_TICK_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_count <= '0;
    else tick_count <= tick_count + {15'b0, tick_nx};
  end
`endif
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: scoreboard bench; stimulus queues expected outputs, a negedge monitor compares.
module tb_clock_divider_prog;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic div_load = 1'b0;
  logic [15:0] div_value = '0;
  logic divclock, tick, busy;
`ifdef CLKDIV_TICK_COUNT_EN
  logic [15:0] tick_count;
`endif
  typedef struct {
    logic t;
    logic d;
    logic b;
    logic chk_tc;
    logic [15:0] tc;
    string name;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  clock_divider_prog dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .div_load(div_load),
    .div_value(div_value),
    .divclock(divclock),
    .tick(tick),
`ifdef CLKDIV_TICK_COUNT_EN
    .tick_count(tick_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      tests++;
      if ({tick, divclock, busy} !== {x.t, x.d, x.b}) begin
        fails++;
        $display("FAIL %s: got tick/divclock/busy=%b%b%b, want %b%b%b", x.name, tick, divclock, busy, x.t, x.d, x.b);
      end
`ifdef CLKDIV_TICK_COUNT_EN
      if (x.chk_tc) begin
        tests++;
        if (tick_count !== x.tc) begin
          fails++;
          $display("FAIL %s: got tick_count=%0d, want %0d", x.name, tick_count, x.tc);
        end
      end
`endif
    end
  end

  task automatic push(input logic t, input logic d, input logic b, input logic c, input logic [15:0] tc, input string nm);
    exp_t x;
    x.t = t;
    x.d = d;
    x.b = b;
    x.chk_tc = c;
    x.tc = tc;
    x.name = nm;
    q.push_back(x);
  endtask

  task automatic cyc(input logic e, input logic ld, input logic [15:0] v, input logic t, input logic d, input logic b, input string nm);
    en = e;
    div_load = ld;
    div_value = v;
    @(posedge clk);
    push(t, d, b, 1'b0, 16'd0, nm);
    #1;
  endtask

  // k counts edges since entering RUN; tick on every N-th edge, divclock high for the first ceil(N/2) cycles.
  task automatic run(input int n, input int cycles, input int k0, input string nm);
    for (int k = k0; k < k0 + cycles; k++)
      cyc(1'b1, 1'b0, 16'd0, (k % n == 0) && (k != 0), (k % n) < (n + 1) / 2, 1'b1, nm);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, "reset");
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, "idle");
    cyc(0, 1, 4, 0, 0, 0, "load4_idle");
    run(4, 13, 0, "n4");
    cyc(0, 0, 0, 0, 0, 0, "drop_en_mid");
    cyc(0, 1, 5, 0, 0, 0, "load5_idle");
    run(5, 11, 0, "n5");
    cyc(0, 0, 0, 0, 0, 0, "exit5");
    cyc(0, 1, 4, 0, 0, 0, "load4_again");
    run(4, 2, 0, "n4_pre");
    cyc(1, 1, 8, 0, 0, 1, "load8_at_cnt1");
    cyc(1, 0, 0, 0, 0, 1, "n4_tail");
    run(8, 17, 8, "n8");
    cyc(0, 0, 0, 0, 0, 0, "exit8");
    cyc(0, 1, 0, 0, 0, 0, "load0");
    run(1, 5, 0, "n0_clamp");
    cyc(0, 0, 0, 0, 0, 0, "exit0");
    cyc(0, 1, 1, 0, 0, 0, "load1");
    run(1, 5, 0, "n1");
    cyc(0, 0, 0, 0, 0, 0, "exit1");
    cyc(0, 1, 6, 0, 0, 0, "load6");
    run(6, 2, 0, "n6");
    cyc(1, 1, 3, 0, 1, 1, "n6_pend3");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, "rst_mid");
    rst_n = 1'b1;
    run(2, 6, 0, "default_after_rst");
    cyc(0, 0, 0, 0, 0, 0, "exit_def");
`ifdef CLKDIV_TICK_COUNT_EN
    cyc(0, 0, 0, 0, 0, 0, "idle_pre_tc");
    rst_n = 1'b0;
    en = 1'b0;
    div_load = 1'b0;
    @(posedge clk);
    push(0, 0, 0, 1'b1, 16'd0, "tc_reset");
    #1;
    rst_n = 1'b1;
    cyc(0, 1, 1, 0, 0, 0, "tc_load1");
    cyc(1, 0, 0, 0, 1, 1, "tc_enter");
    for (int i = 0; i < 65537; i++) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    push(0, 0, 0, 1'b1, 16'd1, "tc_wrap");
    #1;
`endif
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
